sram_access_sequencer: RTL and testbench
========================================

// Module: sram_access_sequencer
// PURPOSE
//  Sequences and shares the 1M x 16 async waveform SRAM between three requesters:
//  ADC capture writer (cap), reference-compare reader (cmp), USB FIFO readout (usb).
//  Owns all SRAM strobes (ADX, DX drive, CEX=OE_n, CEY=WE_n, CE1/CE2, BHE/BLE) and
//  enforces setup/strobe/hold timing so the mode logic only issues req/addr/data.
// PARAMETERS
//  ADR_W   20  SRAM address width
//  DAT_W   16  SRAM data width
//  WE_CYC  2   cycles WE_n held low per write (8 ns CLK -> 16 ns)
//  RD_CYC  3   cycles OE_n held low before read data sampled (24 ns)
// PORTS
//  CLK         in   1      system clock, 125 MHz
//  RST         in   1      asynchronous reset, active-high
//  cap_req     in   1      write request; hold with cap_adr/cap_wd until cap_gnt
//  cap_adr     in   ADR_W  write address
//  cap_wd      in   DAT_W  write data
//  cap_gnt     out  1      1-cycle pulse: write accepted, inputs latched
//  cmp_req     in   1      compare read request; hold until cmp_gnt
//  cmp_adr     in   ADR_W  compare read address
//  cmp_gnt     out  1      1-cycle accept pulse
//  cmp_rvalid  out  1      1-cycle pulse: cmp_rd valid
//  cmp_rd      out  DAT_W  compare read data (held until next cmp_rvalid)
//  usb_req/usb_adr/usb_gnt/usb_rvalid/usb_rd   as cmp_*, for USB readout
//  ADX         out  ADR_W  SRAM address
//  DX_I        in   DAT_W  SRAM data in (from pad)
//  DX_O        out  DAT_W  SRAM data out (to pad)
//  DX_OE       out  1      pad drive enable for DX_O
//  CEX         out  1      SRAM OE_n
//  CEY         out  1      SRAM WE_n
//  CE1,CE2,BHE,BLE out 1   chip/byte enables (static active)
//  busy        out  1      high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, any state): ADX=0, DX_O=0, DX_OE=0, CEX=1, CEY=1, CE1=0, CE2=1,
//   BHE=0, BLE=0, all gnt/rvalid=0, cmp_rd=usb_rd=0, busy=0, state=IDLE; in-flight op dropped,
//   no gnt/rvalid emitted for it.
//  FSM: IDLE, W_SETUP, W_STRB, W_HOLD, R_SETUP, R_WAIT, R_DONE.
//  IDLE: pick one requester (see arbitration); pulse its gnt, latch addr (+data), go
//   W_SETUP or R_SETUP. No request -> stay, strobes inactive.
//  Write: W_SETUP 1 cyc (ADX, DX_O valid, DX_OE=1, CEY=1); W_STRB WE_CYC cyc (CEY=0);
//   W_HOLD 1 cyc (CEY=1, DX_OE still 1); -> IDLE (DX_OE=0). Occupancy WE_CYC+3 cycles.
//  Read: R_SETUP 1 cyc (ADX valid, CEX=1); R_WAIT RD_CYC cyc (CEX=0), DX_I sampled on
//   last R_WAIT edge; R_DONE 1 cyc (CEX=1, rvalid to owner) -> IDLE. gnt at T -> rvalid at T+RD_CYC+2.
//  Invariant: DX_OE=1 and CEX=0 never in same cycle; CEX and CEY never both 0.
//  Arbitration: cap > cmp > usb, evaluated only in IDLE. Requests withdrawn before gnt
//   are legal and ignored. Req still high the cycle after gnt counts as a new request.
//  ADX holds last address in IDLE; no wrap logic (requesters own addressing).
// CONFIGURATION
//  SRAM_SEQ_RR_EN defined: cap stays highest; cmp/usb alternate round-robin using a
//   last-read-owner bit (reset favours cmp), preventing USB starvation during compare.
//  Undefined: strict fixed priority cap > cmp > usb.
// STRUCTURE
//  Package sram_seq_pkg: state encoding, requester IDs (CAP=0,CMP=1,USB=2), static
//   enable levels (CE1=0,CE2=1,BHE=0,BLE=0), default timing constants.
//  Sub-module sram_seq_pick: combinational requester select + RR pointer register.
// TESTING
//  1 cap_req, adr=0x00010, wd=0x0150 -> gnt T, CEY=0 T+2..T+3, DX_OE low at T+5.
//  2 cmp_req adr=0x40000, model returns 0x03A5 -> cmp_rvalid T+5, cmp_rd=0x03A5.
//  3 cap/cmp/usb req same cycle -> grant order cap, cmp, usb; invariants hold throughout.
//  4 cmp+usb held 20 reads: RR_EN -> alternate cmp,usb,...; fixed -> cmp only.
//  5 RST asserted mid-R_WAIT -> CEX=1 immediately, no cmp_rvalid; next req served normally.
//  6 write then read back to back -> DX_OE=0 at least 1 cycle before CEX=0; data matches.

Source files
------------

// File: rtl/sram_seq_pkg.sv
// Shared types and constants for the SRAM access sequencer: FSM states, requester IDs,
// static chip/byte-enable levels and default timing.
package sram_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_W_SETUP = 3'd1,
      ST_W_STRB  = 3'd2,
      ST_W_HOLD  = 3'd3,
      ST_R_SETUP = 3'd4,
      ST_R_WAIT  = 3'd5,
      ST_R_DONE  = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      REQ_CAP = 2'd0,
      REQ_CMP = 2'd1,
      REQ_USB = 2'd2
   } req_id_e;

   // The chip is permanently selected with both bytes enabled.
   localparam logic CE1_LVL = 1'b0;
   localparam logic CE2_LVL = 1'b1;
   localparam logic BHE_LVL = 1'b0;
   localparam logic BLE_LVL = 1'b0;

   localparam int DEF_ADR_W  = 20;
   localparam int DEF_DAT_W  = 16;
   localparam int DEF_WE_CYC = 2;
   localparam int DEF_RD_CYC = 3;

   localparam int CNT_W = 8;

   function automatic logic isRead(req_id_e id);
      return id != REQ_CAP;
   endfunction

endpackage

// File: rtl/sram_seq_pick.sv
// Requester select: cap always wins. With SRAM_SEQ_RR_EN defined, cmp and usb alternate
// through a last-read-owner bit (reset favours cmp); otherwise cmp strictly beats usb.
module sram_seq_pick
   import sram_seq_pkg::*;
(
`ifdef SRAM_SEQ_RR_EN
   input  logic    clk_i,
   input  logic    rst_i,
   input  logic    accept_i,
`endif
   input  logic    capReq_i,
   input  logic    cmpReq_i,
   input  logic    usbReq_i,
   output logic    valid_o,
   output req_id_e id_o
);

`ifdef SRAM_SEQ_RR_EN
   logic preferUsb_q, preferUsb_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         preferUsb_q <= 1'b0;
      end else begin
         preferUsb_q <= preferUsb_d;
      end
   end

   always_comb begin
      valid_o     = 1'b1;
      id_o        = REQ_CAP;
      preferUsb_d = preferUsb_q;
      if (capReq_i) begin
         id_o = REQ_CAP;
      end else if (cmpReq_i && usbReq_i) begin
         id_o = preferUsb_q ? REQ_USB : REQ_CMP;
      end else if (cmpReq_i) begin
         id_o = REQ_CMP;
      end else if (usbReq_i) begin
         id_o = REQ_USB;
      end else begin
         valid_o = 1'b0;
      end
      // Only a granted read moves the pointer; writes leave the cmp/usb balance alone.
      if (accept_i && valid_o && (id_o != REQ_CAP)) begin
         preferUsb_d = (id_o == REQ_CMP);
      end
   end
`else
   always_comb begin
      valid_o = 1'b1;
      id_o    = REQ_CAP;
      if (capReq_i) begin
         id_o = REQ_CAP;
      end else if (cmpReq_i) begin
         id_o = REQ_CMP;
      end else if (usbReq_i) begin
         id_o = REQ_USB;
      end else begin
         valid_o = 1'b0;
      end
   end
`endif

endmodule

// File: rtl/sram_access_sequencer.sv
// Shares the async waveform SRAM between capture writer, compare reader and USB readout,
// owning all strobes and timing. Define SRAM_SEQ_RR_EN for cmp/usb round-robin.
module sram_access_sequencer
   import sram_seq_pkg::*;
#(
   parameter int ADR_W  = DEF_ADR_W,
   parameter int DAT_W  = DEF_DAT_W,
   parameter int WE_CYC = DEF_WE_CYC,
   parameter int RD_CYC = DEF_RD_CYC
)(
   input  logic             CLK,
   input  logic             RST,
   input  logic             cap_req,
   input  logic [ADR_W-1:0] cap_adr,
   input  logic [DAT_W-1:0] cap_wd,
   output logic             cap_gnt,
   input  logic             cmp_req,
   input  logic [ADR_W-1:0] cmp_adr,
   output logic             cmp_gnt,
   output logic             cmp_rvalid,
   output logic [DAT_W-1:0] cmp_rd,
   input  logic             usb_req,
   input  logic [ADR_W-1:0] usb_adr,
   output logic             usb_gnt,
   output logic             usb_rvalid,
   output logic [DAT_W-1:0] usb_rd,
   output logic [ADR_W-1:0] ADX,
   input  logic [DAT_W-1:0] DX_I,
   output logic [DAT_W-1:0] DX_O,
   output logic             DX_OE,
   output logic             CEX,
   output logic             CEY,
   output logic             CE1,
   output logic             CE2,
   output logic             BHE,
   output logic             BLE,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ADR_W-1:0] adx_q, adx_d;
   logic [DAT_W-1:0] dxO_q, dxO_d;
   logic [DAT_W-1:0] cmpRd_q, cmpRd_d;
   logic [DAT_W-1:0] usbRd_q, usbRd_d;
   req_id_e          owner_q, owner_d;
   logic             cex_q, cex_d;
   logic             cey_q, cey_d;
   logic             dxOe_q, dxOe_d;

   logic             grantEn;
   logic             pickValid;
   req_id_e          pickId;
   logic             capGnt, cmpGnt, usbGnt;

   // Grants are suppressed while reset is held so no accept pulse escapes during reset.
   assign grantEn = (state_q == ST_IDLE) && !RST;

   sram_seq_pick uPick (
`ifdef SRAM_SEQ_RR_EN
      .clk_i    (CLK),
      .rst_i    (RST),
      .accept_i (grantEn),
`endif
      .capReq_i (cap_req),
      .cmpReq_i (cmp_req),
      .usbReq_i (usb_req),
      .valid_o  (pickValid),
      .id_o     (pickId)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         adx_q   <= '0;
         dxO_q   <= '0;
         cmpRd_q <= '0;
         usbRd_q <= '0;
         owner_q <= REQ_CAP;
         cex_q   <= 1'b1;
         cey_q   <= 1'b1;
         dxOe_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adx_q   <= adx_d;
         dxO_q   <= dxO_d;
         cmpRd_q <= cmpRd_d;
         usbRd_q <= usbRd_d;
         owner_q <= owner_d;
         cex_q   <= cex_d;
         cey_q   <= cey_d;
         dxOe_q  <= dxOe_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adx_d   = adx_q;
      dxO_d   = dxO_q;
      cmpRd_d = cmpRd_q;
      usbRd_d = usbRd_q;
      owner_d = owner_q;
      capGnt  = 1'b0;
      cmpGnt  = 1'b0;
      usbGnt  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (grantEn && pickValid) begin
               owner_d = pickId;
               case (pickId)
                  REQ_CAP: begin
                     capGnt = 1'b1;
                     adx_d  = cap_adr;
                     dxO_d  = cap_wd;
                  end
                  REQ_CMP: begin
                     cmpGnt = 1'b1;
                     adx_d  = cmp_adr;
                  end
                  default: begin
                     usbGnt = 1'b1;
                     adx_d  = usb_adr;
                  end
               endcase
               state_d = isRead(pickId) ? ST_R_SETUP : ST_W_SETUP;
            end
         end
         ST_W_SETUP: begin
            cnt_d   = CNT_W'(WE_CYC - 1);
            state_d = ST_W_STRB;
         end
         ST_W_STRB: begin
            if (cnt_q == '0) begin
               state_d = ST_W_HOLD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_W_HOLD: begin
            state_d = ST_IDLE;
         end
         ST_R_SETUP: begin
            cnt_d   = CNT_W'(RD_CYC - 1);
            state_d = ST_R_WAIT;
         end
         ST_R_WAIT: begin
            // Read data is captured on the edge that ends the last OE_n-low cycle.
            if (cnt_q == '0) begin
               state_d = ST_R_DONE;
               if (owner_q == REQ_CMP) begin
                  cmpRd_d = DX_I;
               end else begin
                  usbRd_d = DX_I;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_R_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Strobes are registered from the next state so the pads see clean flop outputs.
      cex_d  = (state_d != ST_R_WAIT);
      cey_d  = (state_d != ST_W_STRB);
      dxOe_d = (state_d == ST_W_SETUP) || (state_d == ST_W_STRB) || (state_d == ST_W_HOLD);
   end

   assign cap_gnt    = capGnt;
   assign cmp_gnt    = cmpGnt;
   assign usb_gnt    = usbGnt;
   assign cmp_rvalid = (state_q == ST_R_DONE) && (owner_q == REQ_CMP);
   assign usb_rvalid = (state_q == ST_R_DONE) && (owner_q == REQ_USB);
   assign cmp_rd     = cmpRd_q;
   assign usb_rd     = usbRd_q;

   assign ADX   = adx_q;
   assign DX_O  = dxO_q;
   assign DX_OE = dxOe_q;
   assign CEX   = cex_q;
   assign CEY   = cey_q;
   assign CE1   = CE1_LVL;
   assign CE2   = CE2_LVL;
   assign BHE   = BHE_LVL;
   assign BLE   = BLE_LVL;
   assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Bench for sram_access_sequencer: queue-driven requesters, an SRAM pin model and a
// transaction-timeline reference checked every cycle. Honours SRAM_SEQ_RR_EN.
module tb_sram_access_sequencer;

   localparam int WE = 2;
   localparam int RD = 3;

   typedef struct {
      logic [19:0] adr;
      logic [15:0] wd;
   } reqItem_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        cap_req = 1'b0, cmp_req = 1'b0, usb_req = 1'b0;
   logic [19:0] cap_adr = '0, cmp_adr = '0, usb_adr = '0;
   logic [15:0] cap_wd = '0;
   logic        cap_gnt, cmp_gnt, usb_gnt, cmp_rvalid, usb_rvalid;
   logic [15:0] cmp_rd, usb_rd;
   logic [19:0] ADX;
   logic [15:0] DX_I = 16'hDEAD;
   logic [15:0] DX_O;
   logic        DX_OE, CEX, CEY, CE1, CE2, BHE, BLE, busy;

   int checks = 0;
   int errors = 0;

   reqItem_t capQ[$], cmpQ[$], usbQ[$];
   int       gntLog[$];

   logic [15:0] sramMem [logic [19:0]];
   logic [15:0] expMem  [logic [19:0]];
   int          cexLowCnt = 0;

   sram_access_sequencer dut (
      .CLK(CLK), .RST(RST),
      .cap_req(cap_req), .cap_adr(cap_adr), .cap_wd(cap_wd), .cap_gnt(cap_gnt),
      .cmp_req(cmp_req), .cmp_adr(cmp_adr), .cmp_gnt(cmp_gnt),
      .cmp_rvalid(cmp_rvalid), .cmp_rd(cmp_rd),
      .usb_req(usb_req), .usb_adr(usb_adr), .usb_gnt(usb_gnt),
      .usb_rvalid(usb_rvalid), .usb_rd(usb_rd),
      .ADX(ADX), .DX_I(DX_I), .DX_O(DX_O), .DX_OE(DX_OE),
      .CEX(CEX), .CEY(CEY), .CE1(CE1), .CE2(CE2), .BHE(BHE), .BLE(BLE),
      .busy(busy)
   );

   always #4 CLK = ~CLK;

   function automatic logic [15:0] dflt(logic [19:0] a);
      return a[15:0] ^ 16'hA5C3;
   endfunction

   function automatic int arb(logic c, logic m, logic u, bit pref);
      if (c) return 0;
`ifdef SRAM_SEQ_RR_EN
      if (m && u) return pref ? 2 : 1;
`endif
      if (m) return 1;
      if (u) return 2;
      return -1;
   endfunction

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input int who, input logic [19:0] adr, input logic [15:0] wd);
      reqItem_t it;
      it.adr = adr;
      it.wd  = wd;
      case (who)
         0: capQ.push_back(it);
         1: cmpQ.push_back(it);
         default: usbQ.push_back(it);
      endcase
   endtask

   // Requesters keep req high with the queue head until granted.
   always @(posedge CLK) begin
      #1;
      cap_req = (capQ.size() > 0);
      if (capQ.size() > 0) begin cap_adr = capQ[0].adr; cap_wd = capQ[0].wd; end
      cmp_req = (cmpQ.size() > 0);
      if (cmpQ.size() > 0) cmp_adr = cmpQ[0].adr;
      usb_req = (usbQ.size() > 0);
      if (usbQ.size() > 0) usb_adr = usbQ[0].adr;
   end

   always @(negedge CLK) begin
      if (cap_gnt && capQ.size() > 0) void'(capQ.pop_front());
      if (cmp_gnt && cmpQ.size() > 0) void'(cmpQ.pop_front());
      if (usb_gnt && usbQ.size() > 0) void'(usbQ.pop_front());
   end

   // SRAM pin model: data appears only once OE_n has been low for the full access time.
   always @(negedge CLK) begin
      if (!CEY && DX_OE) sramMem[ADX] = DX_O;
      cexLowCnt = CEX ? 0 : cexLowCnt + 1;
      if (!CEX && cexLowCnt >= RD)
         DX_I = sramMem.exists(ADX) ? sramMem[ADX] : dflt(ADX);
      else
         DX_I = 16'hDEAD;
   end

   // Reference model: each accepted transaction defines a strobe timeline from its grant cycle.
   int          cyc = 0;
   bit          opActive = 0;
   bit          opWrite = 0;
   int          opStart = 0, opOwner = 0, expId = 0, k = 0, lenOp = 0;
   logic [19:0] opAdr = '0, lastAdr = '0;
   logic [15:0] opData = '0, expCmpRd = '0, expUsbRd = '0, rdVal = '0;
   bit          preferUsb = 0;
   int          lastOeCyc = -100;

   always @(negedge CLK) begin
      cyc++;
      checkOutput("ce1", CE1, 0);
      checkOutput("ce2", CE2, 1);
      checkOutput("bhe", BHE, 0);
      checkOutput("ble", BLE, 0);
      checkOutput("invOeCex", DX_OE && !CEX, 0);
      checkOutput("invCexCey", !CEX && !CEY, 0);
      if (!CEX) checkOutput("oeGap", (cyc - lastOeCyc) >= 2, 1);
      if (DX_OE) lastOeCyc = cyc;
      if (cap_gnt) gntLog.push_back(0);
      if (cmp_gnt) gntLog.push_back(1);
      if (usb_gnt) gntLog.push_back(2);

      if (RST) begin
         opActive  = 0;
         lastAdr   = '0;
         expCmpRd  = '0;
         expUsbRd  = '0;
         preferUsb = 0;
         checkOutput("rstAdx", ADX, 0);
         checkOutput("rstDxO", DX_O, 0);
         checkOutput("rstDxOe", DX_OE, 0);
         checkOutput("rstCex", CEX, 1);
         checkOutput("rstCey", CEY, 1);
         checkOutput("rstGnt", {cap_gnt, cmp_gnt, usb_gnt}, 0);
         checkOutput("rstRvalid", {cmp_rvalid, usb_rvalid}, 0);
         checkOutput("rstBusy", busy, 0);
      end else if (!opActive) begin
         expId = arb(cap_req, cmp_req, usb_req, preferUsb);
         checkOutput("idleBusy", busy, 0);
         checkOutput("idleCex", CEX, 1);
         checkOutput("idleCey", CEY, 1);
         checkOutput("idleDxOe", DX_OE, 0);
         checkOutput("idleAdx", ADX, lastAdr);
         checkOutput("capGnt", cap_gnt, expId == 0);
         checkOutput("cmpGnt", cmp_gnt, expId == 1);
         checkOutput("usbGnt", usb_gnt, expId == 2);
         checkOutput("idleRvalid", {cmp_rvalid, usb_rvalid}, 0);
         if (expId >= 0) begin
            opActive = 1;
            opStart  = cyc;
            opOwner  = expId;
            opWrite  = (expId == 0);
            opAdr    = (expId == 0) ? cap_adr : (expId == 1) ? cmp_adr : usb_adr;
            opData   = cap_wd;
            if (opWrite) expMem[opAdr] = opData;
            if (expId == 1) preferUsb = 1;
            if (expId == 2) preferUsb = 0;
            lastAdr = opAdr;
         end
      end else begin
         k     = cyc - opStart;
         lenOp = opWrite ? WE + 2 : RD + 2;
         checkOutput("actBusy", busy, 1);
         checkOutput("actGnt", {cap_gnt, cmp_gnt, usb_gnt}, 0);
         checkOutput("actAdx", ADX, opAdr);
         if (opWrite) begin
            checkOutput("wrCey", CEY, !(k >= 2 && k <= WE + 1));
            checkOutput("wrDxOe", DX_OE, 1);
            checkOutput("wrCex", CEX, 1);
            checkOutput("wrDxO", DX_O, opData);
            checkOutput("wrRvalid", {cmp_rvalid, usb_rvalid}, 0);
         end else begin
            checkOutput("rdCex", CEX, !(k >= 2 && k <= RD + 1));
            checkOutput("rdCey", CEY, 1);
            checkOutput("rdDxOe", DX_OE, 0);
            if (k == RD + 2) begin
               rdVal = expMem.exists(opAdr) ? expMem[opAdr] : dflt(opAdr);
               if (opOwner == 1) expCmpRd = rdVal;
               else expUsbRd = rdVal;
            end
            checkOutput("cmpRvalid", cmp_rvalid, (k == RD + 2) && (opOwner == 1));
            checkOutput("usbRvalid", usb_rvalid, (k == RD + 2) && (opOwner == 2));
         end
         if (k >= lenOp) opActive = 0;
      end
      checkOutput("cmpRd", cmp_rd, expCmpRd);
      checkOutput("usbRd", usb_rd, expUsbRd);
   end

   task automatic waitForGnt(input int who, output bit ok);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if ((who == 0 && cap_gnt) || (who == 1 && cmp_gnt) || (who == 2 && usb_gnt)) begin
            ok = 1;
            break;
         end
      end
      if (!ok) checkOutput("gntTimeout", 0, 1);
   endtask

   task automatic countToRvalid(output int n);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         n++;
         if (cmp_rvalid) return;
      end
      n = -1;
   endtask

   task automatic waitDrained(input int bound);
      bit ok;
      ok = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge CLK);
         if (capQ.size() == 0 && cmpQ.size() == 0 && usbQ.size() == 0 &&
             !cap_req && !cmp_req && !usb_req && !busy) begin
            ok = 1;
            break;
         end
      end
      if (!ok) checkOutput("drainTimeout", 0, 1);
   endtask

   task automatic pulseReset();
      @(posedge CLK);
      #1 RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   function automatic int logAt(int i);
      return (i < gntLog.size()) ? gntLog[i] : -1;
   endfunction

   initial begin
      bit ok;
      int n;
      #1 RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;

      // Test 1: single write, literal strobe timeline.
      applyStimulus(0, 20'h00010, 16'h0150);
      waitForGnt(0, ok);
      for (int i = 1; i <= 5; i++) begin
         @(negedge CLK);
         checkOutput($sformatf("t1Cey%0d", i), CEY, (i == 2 || i == 3) ? 0 : 1);
         checkOutput($sformatf("t1DxOe%0d", i), DX_OE, (i == 5) ? 0 : 1);
      end
      checkOutput("t1Mem", sramMem.exists(20'h00010) ? sramMem[20'h00010] : 16'h0, 16'h0150);

      // Test 2: compare read of preloaded word, rvalid five cycles after grant.
      sramMem[20'h40000] = 16'h03A5;
      expMem[20'h40000]  = 16'h03A5;
      applyStimulus(1, 20'h40000, 16'h0);
      waitForGnt(1, ok);
      countToRvalid(n);
      checkOutput("t2Latency", n, 5);
      checkOutput("t2Data", cmp_rd, 16'h03A5);
      waitDrained(50);

      // Test 3: simultaneous requests are served cap, cmp, usb.
      pulseReset();
      gntLog.delete();
      applyStimulus(0, 20'h00100, 16'h1111);
      applyStimulus(1, 20'h00200, 16'h0);
      applyStimulus(2, 20'h00300, 16'h0);
      waitDrained(100);
      checkOutput("t3Count", gntLog.size(), 3);
      checkOutput("t3First", logAt(0), 0);
      checkOutput("t3Second", logAt(1), 1);
      checkOutput("t3Third", logAt(2), 2);
      checkOutput("t3UsbData", usb_rd, 16'h0300 ^ 16'hA5C3);

      // Test 4: sustained cmp and usb reads.
      pulseReset();
      gntLog.delete();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 20'h01000 + 20'(i), 16'h0);
         applyStimulus(2, 20'h02000 + 20'(i), 16'h0);
      end
      waitDrained(400);
      checkOutput("t4Count", gntLog.size(), 20);
      for (int i = 0; i < 20; i++) begin
`ifdef SRAM_SEQ_RR_EN
         checkOutput($sformatf("t4Order%0d", i), logAt(i), (i % 2 == 0) ? 1 : 2);
`else
         checkOutput($sformatf("t4Order%0d", i), logAt(i), (i < 10) ? 1 : 2);
`endif
      end

      // Test 5: reset during the read wait drops the access.
      applyStimulus(1, 20'h00500, 16'h0);
      waitForGnt(1, ok);
      repeat (3) @(posedge CLK);
      #1 checkOutput("t5CexLowBefore", CEX, 0);
      RST = 1'b1;
      #1 checkOutput("t5CexAfterRst", CEX, 1);
      checkOutput("t5BusyAfterRst", busy, 0);
      @(posedge CLK);
      #1 RST = 1'b0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (cmp_rvalid) n++;
      end
      checkOutput("t5NoRvalid", n, 0);
      applyStimulus(1, 20'h00500, 16'h0);
      waitForGnt(1, ok);
      countToRvalid(n);
      checkOutput("t5Latency", n, 5);
      checkOutput("t5Data", cmp_rd, 16'hA0C3);
      waitDrained(50);

      // Test 6: write then immediate read-back of the same word.
      applyStimulus(0, 20'h00777, 16'hBEEF);
      applyStimulus(1, 20'h00777, 16'h0);
      waitDrained(100);
      checkOutput("t6ReadBack", cmp_rd, 16'hBEEF);

      repeat (3) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      checkOutput("watchdog", 0, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
